// File: rtl/dt_sched_if.sv
// Sample, configuration and result handshake bundle between the temperature front-end and dt_sched.
interface dt_sched_if;
    logic       t_valid;
    logic [7:0] t_in;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       cfg_commit;
    logic       dt_valid;
    logic       dt_ready;
    logic [7:0] dt_data;

    modport master (
        output t_valid, t_in, cfg_we, cfg_addr, cfg_wdata, cfg_commit, dt_ready,
        input  dt_valid, dt_data
    );
    modport slave (
        input  t_valid, t_in, cfg_we, cfg_addr, cfg_wdata, cfg_commit, dt_ready,
        output dt_valid, dt_data
    );
endinterface

// File: rtl/dt_sched.sv
// Sequencer for the internal dT estimator: INIT, warm-up discard, staged config and result handshake.
// Optional DT_SCHED_TIMEOUT_EN adds the sample watchdog and FAULT state.
module dt_sched #(
    parameter int WARMUP_N    = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       clr_fault_i,
    dt_sched_if.slave  bus,
    output logic [7:0] est_T_cur_o,
    output logic [7:0] est_alpha_o,
    output logic [7:0] est_k_dt_o,
    output logic [7:0] est_d_max_o,
    output logic       est_init_o,
    output logic       est_step_o,
    input  logic [7:0] est_dT_i,
    output logic       busy_o,
    output logic       fault_o,
    output logic       ovf_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_WARM  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;
    localparam logic [7:0] WN_LAST = 8'(WARMUP_N - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] wcnt_q;
    logic [7:0] t_cur_q;
    logic [7:0] sh_alpha_q, sh_kdt_q, sh_dmax_q;
    logic [7:0] alpha_q, kdt_q, dmax_q;
    logic       step_q;
    logic [1:0] pub_pipe_q;
    logic       dt_valid_q, dt_valid_d;
    logic [7:0] dt_data_q, dt_data_d;
    logic       ovf_q, ovf_d;
    logic       live, accept, timeout, cap;

    assign live = (state_q == S_WARM) || (state_q == S_RUN);

`ifdef DT_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
    logic [WDW-1:0] wdog_q;

    assign timeout = (wdog_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst || !live || accept) wdog_q <= '0;
        else                        wdog_q <= wdog_q + 1'b1;
    end
`else
    localparam logic [31:0] TO_BITS = 32'(TIMEOUT_CYC);
    logic unused_to;
    assign unused_to = ^{clr_fault_i, TO_BITS};
    assign timeout   = 1'b0;
`endif

    // enable=0 beats commit, commit beats clr_fault and samples
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (!enable_i)           state_d = S_IDLE;
        else if (bus.cfg_commit) state_d = S_INIT;
        else begin
            case (state_q)
                S_IDLE: state_d = S_INIT;
                S_INIT: state_d = S_WARM;
                S_WARM, S_RUN: begin
                    accept = bus.t_valid;
                    if (accept && state_q == S_WARM && wcnt_q == WN_LAST) state_d = S_RUN;
                    else if (!accept && timeout)                          state_d = S_FAULT;
                end
                S_FAULT: begin
`ifdef DT_SCHED_TIMEOUT_EN
                    if (clr_fault_i) state_d = S_INIT;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // pub_pipe marks steps taken in RUN; warm-up results never reach the handshake
    assign cap = pub_pipe_q[1] && (state_q == S_RUN) && (state_d == S_RUN);

    always_comb begin
        dt_valid_d = dt_valid_q;
        dt_data_d  = dt_data_q;
        ovf_d      = ovf_q;
        if (state_d != S_RUN) dt_valid_d = 1'b0;
        else if (cap) begin
            dt_data_d  = est_dT_i;
            dt_valid_d = 1'b1;
            if (dt_valid_q && !bus.dt_ready) ovf_d = 1'b1;
        end else if (dt_valid_q && bus.dt_ready) dt_valid_d = 1'b0;
        if (state_d == S_INIT) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            t_cur_q    <= '0;
            sh_alpha_q <= '0;
            sh_kdt_q   <= '0;
            sh_dmax_q  <= 8'd127;
            alpha_q    <= '0;
            kdt_q      <= '0;
            dmax_q     <= 8'd127;
            step_q     <= 1'b0;
            pub_pipe_q <= '0;
            dt_valid_q <= 1'b0;
            dt_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= accept;
            pub_pipe_q <= {pub_pipe_q[0], accept && (state_q == S_RUN)};
            dt_valid_q <= dt_valid_d;
            dt_data_q  <= dt_data_d;
            ovf_q      <= ovf_d;
            if (accept) t_cur_q <= bus.t_in;
            if (state_q == S_INIT) begin
                wcnt_q  <= '0;
                alpha_q <= sh_alpha_q;
                kdt_q   <= sh_kdt_q;
                dmax_q  <= sh_dmax_q;
            end else if (accept && state_q == S_WARM) begin
                wcnt_q <= wcnt_q + 8'd1;
            end
            if (bus.cfg_we) begin
                case (bus.cfg_addr)
                    2'd0:    sh_alpha_q <= bus.cfg_wdata;
                    2'd1:    sh_kdt_q   <= bus.cfg_wdata;
                    2'd2:    sh_dmax_q  <= bus.cfg_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign est_T_cur_o  = t_cur_q;
    assign est_alpha_o  = alpha_q;
    assign est_k_dt_o   = kdt_q;
    assign est_d_max_o  = dmax_q;
    assign est_init_o   = (state_q == S_INIT);
    assign est_step_o   = step_q;
    assign busy_o       = (state_q == S_INIT) || (state_q == S_WARM);
    assign fault_o      = (state_q == S_FAULT);
    assign ovf_o        = ovf_q;
    assign bus.dt_valid = dt_valid_q;
    assign bus.dt_data  = dt_data_q;
endmodule

// File: tb/tb_dt_sched.sv
// Scoreboard bench for dt_sched; a stand-in estimator answers each est_step with est_T_cur+3.
`timescale 1ns/1ps
module tb_dt_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       clr_fault = 1'b0;
    logic [7:0] est_T_cur, est_alpha, est_k_dt, est_d_max;
    logic [7:0] est_dT;
    logic       est_init, est_step, busy, fault, ovf;
    int         n_chk = 0;
    int         n_err = 0;
    logic       sb_on = 1'b0;
    logic [7:0] sb_q[$];
    logic [7:0] sb_e;

    dt_sched_if bus();

    always #5 clk = ~clk;

    dt_sched #(.WARMUP_N(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .clr_fault_i(clr_fault), .bus(bus),
        .est_T_cur_o(est_T_cur), .est_alpha_o(est_alpha), .est_k_dt_o(est_k_dt),
        .est_d_max_o(est_d_max), .est_init_o(est_init), .est_step_o(est_step),
        .est_dT_i(est_dT), .busy_o(busy), .fault_o(fault), .ovf_o(ovf)
    );

    always @(posedge clk) begin
        if (rst)           est_dT <= 8'd0;
        else if (est_step) est_dT <= est_T_cur + 8'd3;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        bus.t_valid = 1'b1;
        bus.t_in    = v;
        tick();
        bus.t_valid = 1'b0;
    endtask

    task automatic wcfg(input logic [1:0] a, input logic [7:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic check_reset();
        chk("rst_T_cur", est_T_cur, 0);
        chk("rst_alpha", est_alpha, 0);
        chk("rst_k_dt", est_k_dt, 0);
        chk("rst_d_max", est_d_max, 127);
        chk("rst_init", est_init, 0);
        chk("rst_step", est_step, 0);
        chk("rst_dt_valid", bus.dt_valid, 0);
        chk("rst_dt_data", bus.dt_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ovf", ovf, 0);
    endtask

    // results are consumed on the negedge before the handshake edge
    always @(negedge clk) begin
        if (sb_on && !rst && bus.dt_valid && bus.dt_ready) begin
            if (sb_q.size() == 0) chk("sb_unexpected", 1, 0);
            else begin
                sb_e = sb_q.pop_front();
                chk("sb_data", bus.dt_data, sb_e);
            end
        end
    end

    initial begin
        int n;
        bus.t_valid = 0; bus.t_in = 0; bus.cfg_we = 0; bus.cfg_addr = 0;
        bus.cfg_wdata = 0; bus.cfg_commit = 0; bus.dt_ready = 1;
        repeat (2) tick();
        rst = 1'b0;
        check_reset();

        // bring-up, warm-up discard, first result latency
        enable = 1'b1;
        tick();
        chk("init_pulse", est_init, 1);
        chk("busy_init", busy, 1);
        tick();
        chk("init_one_cycle", est_init, 0);
        send(8'd20); send(8'd22); send(8'd24);
        chk("busy_before_4th", busy, 1);
        send(8'd26);
        chk("busy_after_4th", busy, 0);
        sb_on = 1'b1;
        sb_q.push_back(8'd31);
        send(8'd28);
        chk("step_n1", est_step, 1);
        chk("T_cur_n1", est_T_cur, 28);
        tick();
        chk("dt_valid_n2", bus.dt_valid, 0);
        tick();
        chk("dt_valid_n3", bus.dt_valid, 1);
        chk("dt_data_n3", bus.dt_data, 31);
        foreach (sb_q[i]) chk("sb_pre_b2b", sb_q[i], 31);
        for (int v = 30; v <= 34; v += 2) begin
            sb_q.push_back(8'(v + 3));
            send(8'(v));
        end
        repeat (5) tick();
        chk("sb_drain", sb_q.size(), 0);
        sb_on = 1'b0;

        // overwrite while stalled
        bus.dt_ready = 1'b0;
        send(8'd40); send(8'd50);
        tick();
        chk("ovf_first", bus.dt_data, 43);
        chk("ovf_first_v", bus.dt_valid, 1);
        chk("ovf_not_yet", ovf, 0);
        tick();
        chk("ovf_second", bus.dt_data, 53);
        chk("ovf_set", ovf, 1);
        tick();
        chk("ovf_hold", bus.dt_data, 53);
        chk("ovf_hold_v", bus.dt_valid, 1);
        bus.dt_ready = 1'b1;
        tick();
        chk("ovf_accept_drop", bus.dt_valid, 0);
        chk("ovf_sticky", ovf, 1);

        // staged config; sample coincident with commit is dropped
        wcfg(2'd0, 8'd64); wcfg(2'd1, 8'd2); wcfg(2'd2, 8'd10); wcfg(2'd3, 8'd99);
        chk("cfg_stage_alpha", est_alpha, 0);
        chk("cfg_stage_kdt", est_k_dt, 0);
        chk("cfg_stage_dmax", est_d_max, 127);
        bus.cfg_commit = 1'b1; bus.t_valid = 1'b1; bus.t_in = 8'd77;
        tick();
        bus.cfg_commit = 1'b0; bus.t_valid = 1'b0;
        chk("commit_init", est_init, 1);
        chk("commit_ovf_clr", ovf, 0);
        chk("commit_drop_step", est_step, 0);
        chk("commit_drop_T", est_T_cur, 50);
        tick();
        chk("cfg_alpha", est_alpha, 64);
        chk("cfg_kdt", est_k_dt, 2);
        chk("cfg_dmax", est_d_max, 10);

        // capture coincident with acceptance
        bus.dt_ready = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        repeat (3) tick();
        chk("warm_unpub", bus.dt_valid, 0);
        send(8'd60); send(8'd70);
        tick();
        chk("coin_first", bus.dt_data, 63);
        bus.dt_ready = 1'b1;
        tick();
        chk("coin_valid", bus.dt_valid, 1);
        chk("coin_data", bus.dt_data, 73);
        chk("coin_no_ovf", ovf, 0);
        tick();
        chk("coin_drop", bus.dt_valid, 0);

`ifdef DT_SCHED_TIMEOUT_EN
        n = 0;
        chk("fault_idle", fault, 0);
        while (!fault && n < 40) begin
            tick();
            n++;
        end
        chk("fault_set", fault, 1);
        chk("wdog_window", (n >= 11 && n <= 15), 1);
        chk("fault_no_valid", bus.dt_valid, 0);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk("clr_init", est_init, 1);
        chk("clr_fault_low", fault, 0);
        tick();
`else
        n = 0;
        repeat (40) tick();
        chk("no_fault", fault, 0);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk("clr_ignored", est_init, n);
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        tick();
`endif

        // enable dropped mid-warm-up
        send(8'd5); send(8'd6);
        enable = 1'b0; bus.t_valid = 1'b1; bus.t_in = 8'd7;
        tick();
        chk("en_drop_step", est_step, 0);
        chk("en_drop_busy", busy, 0);
        chk("en_drop_valid", bus.dt_valid, 0);
        chk("en_drop_T", est_T_cur, 6);
        tick();
        chk("idle_step", est_step, 0);
        bus.t_valid = 1'b0;

        // reset in RUN with pending result and ovf
        enable = 1'b1;
        tick(); tick();
        send(8'd8); send(8'd9); send(8'd10); send(8'd11);
        bus.dt_ready = 1'b0;
        send(8'd90); send(8'd100);
        repeat (3) tick();
        chk("pre_rst_data", bus.dt_data, 103);
        chk("pre_rst_ovf", ovf, 1);
        rst = 1'b1;
        tick();
        check_reset();
        rst = 1'b0;
        enable = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dt_sched.md
# dt_sched

Sequencing controller for the internal dT estimator (DT_MODE=1). Accepts Q7.0 temperature samples, presents them to the estimator one per sample, manages INIT, warm-up discard, staged configuration (ALPHA, K_DT, D_MAX), a sample-timeout watchdog and a valid/ready output handshake. Sits between the temperature front-end and the estimator; its outputs drive the estimator's inputs directly.

## Interface
- WARMUP_N, default 4: accepted samples discarded after each INIT before results are published (1..255).
- TIMEOUT_CYC, default 1024: maximum clk cycles between accepted samples in WARMUP/RUN (≥2).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; low forces IDLE.
- t_valid  in  1  new temperature sample strobe.
- t_in  in  8  signed Q7.0 sample.
- cfg_we  in  1  shadow register write.
- cfg_addr  in  2  0=ALPHA, 1=K_DT, 2=D_MAX, 3=reserved (write ignored).
- cfg_wdata  in  8  write data.
- cfg_commit  in  1  copy shadow to active and re-initialise.
- clr_fault  in  1  leave FAULT.
- est_T_cur  out  8  signed Q7.0 to estimator T_cur.
- est_alpha, est_k_dt, est_d_max  out  8 each  active configuration.
- est_init  out  1  one-cycle INIT pulse to estimator.
- est_step  out  1  one-cycle update enable to estimator (integration wrapper gates estimator state with it).
- est_dT  in  8  estimator dT_out, signed Q7.0.
- dt_valid  out  1  result available.
- dt_ready  in  1  downstream accepts.
- dt_data  out  8  signed Q7.0 result.
- busy  out  1  state is INIT or WARMUP.
- fault  out  1  state is FAULT.
- ovf  out  1  sticky: unconsumed result overwritten; cleared by INIT.

## Operation
- States: IDLE, INIT, WARMUP, RUN, FAULT. Reset → IDLE.
- Reset values: est_T_cur=0, est_alpha=0, est_k_dt=0, est_d_max=127 (shadow identical), est_init=0, est_step=0, dt_valid=0, dt_data=0, busy=0, fault=0, ovf=0.
- IDLE: enable=1 → INIT.
- INIT (one cycle): est_init=1, active cfg ← shadow, warm-up counter=0, dt_valid=0, ovf=0 → WARMUP.
- Sample acceptance (WARMUP/RUN): t_valid=1 → est_T_cur ← t_in, est_step=1 on the following cycle, watchdog cleared.
- WARMUP: each acceptance increments counter; when count reaches WARMUP_N → RUN. Estimator results are not published.
- RUN: one cycle after est_step, dt_data ← est_dT, dt_valid=1. Handshake: dt_valid held until dt_valid&dt_ready; dt_data stable while dt_valid=1 and not accepted. A new capture while unaccepted overwrites dt_data and sets ovf. Capture coincident with acceptance: the new value loads, dt_valid stays 1, no ovf.
- cfg_we: writes shadow in any state; active cfg changes only in INIT.
- cfg_commit in WARMUP/RUN/IDLE(with enable) → INIT next cycle; a sample arriving with commit is dropped.
- enable=0 in any state → IDLE next cycle; dt_valid cleared, est_step suppressed.
- FAULT: est_step suppressed, dt_valid=0; clr_fault=1 with enable=1 → INIT. Priority: rst > enable=0 > cfg_commit > clr_fault/sample.
- t_valid in IDLE/INIT/FAULT ignored.

## Timing
- t_valid at cycle N → est_T_cur updated at N+1, est_step high at N+1, est_dT valid at N+2, dt_valid high at N+3 (RUN).
- enable rise at N → est_init high at N+1.
- Back-to-back t_valid every cycle supported; throughput one result per cycle.
- Watchdog: counter counts cycles since last acceptance; reaching TIMEOUT_CYC → FAULT on next cycle.

## Configuration
- DT_SCHED_TIMEOUT_EN defined: watchdog and FAULT state compiled in as above.
- Undefined: no watchdog counter, FAULT unreachable, fault tied 0, clr_fault ignored; TIMEOUT_CYC unused.

## Test plan
- Reset, enable=1, WARMUP_N=4, samples 20,22,24,26,28,30 → est_init one pulse, busy high through 4th sample, first dt_valid after 5th sample, dt_data equals est_dT captured.
- Write ALPHA=64, K_DT=2, D_MAX=10 without commit → est_* unchanged; cfg_commit → INIT pulse, est_alpha=64, est_k_dt=2, est_d_max=10, ovf cleared.
- dt_ready=0, two RUN samples → dt_data = second result, ovf=1; dt_ready=1 → dt_valid drops one cycle later.
- Capture and accept in same cycle → dt_valid stays 1 with new value, ovf=0.
- With DT_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, no samples in RUN → fault=1 after 16 cycles; clr_fault → INIT pulse, fault=0.
- enable dropped mid-WARMUP with t_valid pulses → IDLE, no est_step, dt_valid=0; rst asserted mid-RUN → all outputs at reset values next cycle.
